// File: rtl/spiflash_pkg.sv
// spiflash_pkg: shared types and constants for the SPI-flash ROM bridge.
//   state_t    - bridge FSM states
//   CMD_*      - supported SPI read opcodes
//   addr_mask  - mask that wraps the byte address at the smaller of the
//                SPI address space and the ROM address space
package spiflash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_IGNORE
   } state_t;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_FAST = 8'h0B;
   localparam logic [7:0] CMD_DUAL = 8'h3B;

   function automatic logic [31:0] addr_mask(input int addr_bytes, input int rom_aw);
      int eff;
      eff = (8 * addr_bytes < rom_aw) ? 8 * addr_bytes : rom_aw;
      return (eff >= 32) ? 32'hFFFF_FFFF : ((32'd1 << eff) - 32'd1);
   endfunction

endpackage

// File: rtl/spiflash_rom_bridge_if.sv
// spiflash_rom_bridge_if: BRAM port A between the bridge and the ROM.
//   master - bridge side: drives address/enable/clock/reset, reads Dout
//   slave  - ROM side: returns Dout one clock after EN_A
interface spiflash_rom_bridge_if #(
   parameter int ROM_AW = 32
);
   logic [ROM_AW-1:0] romcode_Addr_A;
   logic              romcode_EN_A;
   logic [3:0]        romcode_WEN_A;
   logic [31:0]       romcode_Din_A;
   logic [31:0]       romcode_Dout_A;
   logic              romcode_Clk_A;
   logic              romcode_Rst_A;

   modport master (
      output romcode_Addr_A, romcode_EN_A, romcode_WEN_A, romcode_Din_A,
             romcode_Clk_A, romcode_Rst_A,
      input  romcode_Dout_A
   );

   modport slave (
      input  romcode_Addr_A, romcode_EN_A, romcode_WEN_A, romcode_Din_A,
             romcode_Clk_A, romcode_Rst_A,
      output romcode_Dout_A
   );
endinterface

// File: rtl/spiflash_edge_sync.sv
// spiflash_edge_sync: two-flop synchroniser plus edge detector.
//   clk, rst  - sampling clock, synchronous active-high reset
//   din       - asynchronous input
//   level     - synchronised level
//   rise/fall - one-clock pulses on synchronised level changes
module spiflash_edge_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   // [1:0] is the synchroniser, [2] is the previous synchronised level.
   logic [2:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= {3{RST_VAL}};
      else     sr <= {sr[1:0], din};
   end

   assign level = sr[1];
   assign rise  = sr[1] & ~sr[2];
   assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/spiflash_rom_bridge.sv
// spiflash_rom_bridge: SPI-flash read slave (0x03 / 0x0B / 0x3B) serving
// bytes out of a 32-bit BRAM. spiclk is oversampled in ap_clk.
//   ap_clk, ap_rst      - system clock, synchronous active-high reset
//   csb, spiclk, io0    - SPI slave inputs (mode 0)
//   io1, io0_o, io0_oe  - serial data out (io0 driven only in dual data)
//   rom                 - BRAM port A (master side)
//   busy, cmd_err       - transaction in progress, sticky bad-opcode flag
//   rd_count            - bytes delivered since reset, saturating
module spiflash_rom_bridge
   import spiflash_pkg::*;
#(
   parameter int ADDR_BYTES   = 3,
   parameter int DUMMY_CYCLES = 8,
   parameter bit DUAL_EN      = 1'b1,
   parameter int ROM_AW       = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  csb,
   input  logic                  spiclk,
   input  logic                  io0,
   output logic                  io0_o,
   output logic                  io0_oe,
   output logic                  io1,
   spiflash_rom_bridge_if.master rom,
   output logic                  busy,
   output logic                  cmd_err,
   output logic [15:0]           rd_count
);
   localparam int          ABITS = 8 * ADDR_BYTES;
   localparam logic [31:0] AMASK = addr_mask(ADDR_BYTES, ROM_AW);

   logic csb_lvl, csb_rise, csb_fall;
   logic sck_lvl, sck_rise, sck_fall;

   spiflash_edge_sync #(.RST_VAL(1'b1)) u_csb_sync (
      .clk(ap_clk), .rst(ap_rst), .din(csb),
      .level(csb_lvl), .rise(csb_rise), .fall(csb_fall)
   );

   spiflash_edge_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clk(ap_clk), .rst(ap_rst), .din(spiclk),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, csb_rise, sck_lvl};

   state_t            state;
   logic [15:0]       cnt;
   logic [6:0]        cmd_sr;
   logic [31:0]       addr;
   logic [31:0]       word;
   logic [7:0]        out_sr;
   logic [2:0]        dbit;
   logic              dual, use_dummy, byte_pend;
   logic              armed;
   logic [1:0]        settle;
   logic [1:0]        io0_d;
   logic [1:0]        vld_pipe;   // [0] read issued (EN_A), [1] Dout valid
   logic [ROM_AW-1:0] rom_addr;

   logic        mosi;
   logic [7:0]  cmd_byte, cur_byte;
   logic [31:0] addr_inc, data_a;
   logic [2:0]  last_bit;
   logic        go_data;

   // io0 is delayed to line up with the synchronised spiclk edge.
   assign mosi     = io0_d[1];
   assign cmd_byte = {cmd_sr, mosi};
   assign addr_inc = (addr + 32'd1) & AMASK;
   assign last_bit = dual ? 3'd3 : 3'd7;
   assign data_a   = (state == ST_ADDR) ? ({addr[30:0], mosi} & AMASK) : (addr & AMASK);

   always_comb begin
      cur_byte = word[7:0];
      case (addr[1:0])
         2'd1:    cur_byte = word[15:8];
         2'd2:    cur_byte = word[23:16];
         2'd3:    cur_byte = word[31:24];
         default: cur_byte = word[7:0];
      endcase
   end

   // Final address rise (no dummy phase) or final dummy rise starts DATA.
   always_comb begin
      go_data = 1'b0;
      if (sck_rise && !csb_lvl) begin
         if (state == ST_ADDR && cnt == 16'(ABITS - 1) && !(use_dummy && DUMMY_CYCLES != 0))
            go_data = 1'b1;
         if (state == ST_DUMMY && cnt == 16'(DUMMY_CYCLES - 1))
            go_data = 1'b1;
      end
   end

   assign busy               = !csb_lvl && (state != ST_IDLE);
   assign rom.romcode_Addr_A = rom_addr;
   assign rom.romcode_EN_A   = vld_pipe[0];
   assign rom.romcode_WEN_A  = 4'd0;
   assign rom.romcode_Din_A  = 32'd0;
   assign rom.romcode_Clk_A  = ap_clk;
   assign rom.romcode_Rst_A  = ap_rst;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cmd_sr    <= '0;
         addr      <= '0;
         word      <= '0;
         out_sr    <= '0;
         dbit      <= '0;
         dual      <= 1'b0;
         use_dummy <= 1'b0;
         byte_pend <= 1'b0;
         armed     <= 1'b0;
         settle    <= '0;
         io0_d     <= '0;
         vld_pipe  <= '0;
         rom_addr  <= '0;
         io1       <= 1'b0;
         io0_o     <= 1'b0;
         io0_oe    <= 1'b0;
         cmd_err   <= 1'b0;
         rd_count  <= '0;
      end else begin
         io0_d    <= {io0_d[0], io0};
         vld_pipe <= {vld_pipe[0], 1'b0};
         if (vld_pipe[1]) word <= rom.romcode_Dout_A;

         // After reset, a command is only accepted once csb has really been
         // seen high, so a csb held low across reset is not a falling edge.
         if (settle != 2'd3) settle <= settle + 2'd1;
         else if (csb_lvl)   armed  <= 1'b1;

         if (csb_lvl) begin
            // csb high wins over any coincident spiclk edge.
            state     <= ST_IDLE;
            io1       <= 1'b0;
            io0_o     <= 1'b0;
            io0_oe    <= 1'b0;
            byte_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (csb_fall && armed) begin
                     state <= ST_CMD;
                     cnt   <= '0;
                  end
               end
               ST_CMD: begin
                  if (sck_rise) begin
                     cmd_sr <= cmd_byte[6:0];
                     cnt    <= cnt + 16'd1;
                     if (cnt == 16'd7) begin
                        cnt  <= '0;
                        addr <= '0;
                        case (cmd_byte)
                           CMD_READ: begin
                              state     <= ST_ADDR;
                              use_dummy <= 1'b0;
                              dual      <= 1'b0;
                           end
                           CMD_FAST: begin
                              state     <= ST_ADDR;
                              use_dummy <= 1'b1;
                              dual      <= 1'b0;
                           end
                           CMD_DUAL: begin
                              if (DUAL_EN) begin
                                 state     <= ST_ADDR;
                                 use_dummy <= 1'b1;
                                 dual      <= 1'b1;
                              end else begin
                                 state   <= ST_IGNORE;
                                 cmd_err <= 1'b1;
                              end
                           end
                           default: begin
                              state   <= ST_IGNORE;
                              cmd_err <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               ST_ADDR: begin
                  if (sck_rise) begin
                     addr <= {addr[30:0], mosi};
                     cnt  <= cnt + 16'd1;
                     if (cnt == 16'(ABITS - 1)) begin
                        cnt   <= '0;
                        state <= ST_DUMMY;
                     end
                  end
               end
               ST_DUMMY: begin
                  if (sck_rise) cnt <= cnt + 16'd1;
               end
               ST_DATA: begin
                  if (sck_fall) begin
                     if (dbit == 3'd0) begin
                        io1 <= cur_byte[7];
                        if (dual) begin
                           io0_o  <= cur_byte[6];
                           out_sr <= {cur_byte[5:0], 2'b00};
                        end else begin
                           out_sr <= {cur_byte[6:0], 1'b0};
                        end
                        // Last lane of the word starts now: fetch the next
                        // word so it lands long before the next byte starts.
                        if (addr[1:0] == 2'd3) begin
                           vld_pipe[0] <= 1'b1;
                           rom_addr    <= ROM_AW'({addr_inc[31:2], 2'b00});
                        end
                     end else begin
                        io1 <= out_sr[7];
                        if (dual) begin
                           io0_o  <= out_sr[6];
                           out_sr <= {out_sr[5:0], 2'b00};
                        end else begin
                           out_sr <= {out_sr[6:0], 1'b0};
                        end
                     end
                     if (dbit == last_bit) begin
                        dbit      <= '0;
                        byte_pend <= 1'b1;
                     end else begin
                        dbit <= dbit + 3'd1;
                     end
                  end else if (sck_rise && byte_pend) begin
                     // Master has sampled the last bit: the byte is delivered.
                     byte_pend <= 1'b0;
                     addr      <= addr_inc;
                     if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                  end
               end
               default: ;   // ST_IGNORE: wait for csb high
            endcase

            if (go_data) begin
               state       <= ST_DATA;
               addr        <= data_a;
               dbit        <= '0;
               byte_pend   <= 1'b0;
               io0_oe      <= dual;
               vld_pipe[0] <= 1'b1;
               rom_addr    <= ROM_AW'({data_a[31:2], 2'b00});
            end
         end
      end
   end
endmodule

// File: tb/tb_spiflash_rom_bridge.sv
// tb_spiflash_rom_bridge: directed and random SPI reads against a byte-stream
// model of the flash (expected byte at address x = ROM byte at x mod 2^24).
module tb_spiflash_rom_bridge;
   localparam int          DUMMY = 8;
   localparam logic [31:0] AMSK  = 32'h00FF_FFFF;

   logic clk = 1'b0, rst = 1'b1, csb = 1'b1, spiclk = 1'b0, io0 = 1'b0;
   logic io0_o, io0_oe, io1, busy, cmd_err;
   logic [15:0] rd_count;

   spiflash_rom_bridge_if #(.ROM_AW(32)) rom_bus ();

   spiflash_rom_bridge #(
      .ADDR_BYTES(3), .DUMMY_CYCLES(DUMMY), .DUAL_EN(1'b1), .ROM_AW(32)
   ) dut (
      .ap_clk(clk), .ap_rst(rst), .csb(csb), .spiclk(spiclk), .io0(io0),
      .io0_o(io0_o), .io0_oe(io0_oe), .io1(io1), .rom(rom_bus),
      .busy(busy), .cmd_err(cmd_err), .rd_count(rd_count)
   );

   always #5 clk = ~clk;

   // ROM contents: byte at a = a+1 for a < 256 (word0 = 0x04030201).
   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      return 8'(a + 32'd1) ^ 8'((a >> 8) * 32'd29) ^ 8'((a >> 16) * 32'd71);
   endfunction

   always_ff @(posedge clk) begin
      if (rom_bus.romcode_EN_A)
         rom_bus.romcode_Dout_A <= {rom_byte(rom_bus.romcode_Addr_A + 32'd3),
                                    rom_byte(rom_bus.romcode_Addr_A + 32'd2),
                                    rom_byte(rom_bus.romcode_Addr_A + 32'd1),
                                    rom_byte(rom_bus.romcode_Addr_A)};
   end

   int pass_cnt = 0, chk_cnt = 0, en_cnt = 0;
   int hp = 4;
   int m_rd = 0;
   logic m_err = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // BRAM reads: count them and require word alignment.
   always @(negedge clk) begin
      if (rom_bus.romcode_EN_A === 1'b1) begin
         en_cnt++;
         check("addr_align", {30'd0, rom_bus.romcode_Addr_A[1:0]}, 32'd0);
      end
   end

   // Compare process: runs just before each spiclk rise.
   event chk_ev;
   logic e_io1, e_io0o, e_oe, e_data, e_busy;
   logic [7:0] rx_sr;
   int rx_n;
   logic [7:0] rx_q[$];

   always @(chk_ev) begin
      check("io1", io1, e_io1);
      check("io0_o", io0_o, e_io0o);
      check("io0_oe", io0_oe, e_oe);
      check("busy", busy, e_busy);
      if (e_data) begin
         if (e_oe) begin rx_sr = {rx_sr[5:0], io1, io0_o}; rx_n += 2; end
         else      begin rx_sr = {rx_sr[6:0], io1};        rx_n += 1; end
         if (rx_n == 8) begin rx_q.push_back(rx_sr); rx_n = 0; end
      end
   end

   task automatic spi_cycle(input logic mosi, input logic x1, input logic x0,
                            input logic xoe, input logic xdata, input bit keep);
      @(negedge clk) io0 = mosi;
      repeat (hp - 1) @(negedge clk);
      e_io1 = x1; e_io0o = x0; e_oe = xoe; e_data = xdata;
      -> chk_ev;
      spiclk = 1'b1;
      repeat (hp) @(negedge clk);
      if (!keep) spiclk = 1'b0;
   endtask

   task automatic rx_expect(input int idx, input logic [7:0] v);
      check($sformatf("rx_byte%0d", idx), (idx < rx_q.size()) ? {24'd0, rx_q[idx]} : 32'hDEAD, {24'd0, v});
   endtask

   task automatic xact(input logic [7:0] cmd, input logic [31:0] a, input int nbytes, input int abort_bits);
      bit ok, fast, dual;
      int bpc, nd, k;
      logic [7:0] b;
      ok   = (cmd == 8'h03) || (cmd == 8'h0B) || (cmd == 8'h3B);
      dual = ok && (cmd == 8'h3B);
      fast = ok && (cmd != 8'h03);
      hp   = $urandom_range(4, 6);
      rx_q.delete(); rx_n = 0;
      e_busy = 1'b1;
      @(negedge clk) csb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++)  spi_cycle(cmd[7-i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) spi_cycle(a[23-i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (ok) begin
         if (fast)
            for (int i = 0; i < DUMMY; i++) spi_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         bpc = dual ? 4 : 8;
         nd  = (abort_bits > 0) ? abort_bits : nbytes * bpc;
         for (int j = 0; j < nd; j++) begin
            b = rom_byte((a + 32'(j / bpc)) & AMSK);
            k = j % bpc;
            if (dual) spi_cycle(1'($urandom_range(0, 1)), b[7-2*k], b[6-2*k], 1'b1, 1'b1, (abort_bits > 0) && (j == nd - 1));
            else      spi_cycle(1'($urandom_range(0, 1)), b[7-k], 1'b0, 1'b0, 1'b1, (abort_bits > 0) && (j == nd - 1));
         end
         m_rd += (abort_bits > 0) ? (abort_bits / bpc) : nbytes;
         if (m_rd > 65535) m_rd = 65535;
      end else begin
         m_err = 1'b1;
      end
      if (abort_bits > 0 && ok) begin
         // csb rises together with the spiclk fall that would drive the next bit.
         spiclk = 1'b0; csb = 1'b1;
         repeat (3) @(negedge clk);
         check("abort_busy", busy, 1'b0);
         check("abort_io1", io1, 1'b0);
         check("abort_oe", io0_oe, 1'b0);
      end else begin
         @(negedge clk) csb = 1'b1;
      end
      repeat (4) @(negedge clk);
      check("end_busy", busy, 1'b0);
      check("end_io1", io1, 1'b0);
      check("end_oe", io0_oe, 1'b0);
      check("rd_count", {16'd0, rd_count}, 32'(m_rd));
      check("cmd_err", cmd_err, m_err);
   endtask

   task automatic chk_reset_vals(input string tag);
      check({tag, "_io1"}, io1, 1'b0);
      check({tag, "_io0_o"}, io0_o, 1'b0);
      check({tag, "_io0_oe"}, io0_oe, 1'b0);
      check({tag, "_en"}, rom_bus.romcode_EN_A, 1'b0);
      check({tag, "_addr"}, rom_bus.romcode_Addr_A, 32'd0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_cmd_err"}, cmd_err, 1'b0);
      check({tag, "_rd_count"}, {16'd0, rd_count}, 32'd0);
      check({tag, "_rst_a"}, rom_bus.romcode_Rst_A, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0, rc0, r, nb;
      logic [7:0] c;
      e_io1 = 0; e_io0o = 0; e_oe = 0; e_data = 0; e_busy = 0;
      rx_sr = '0; rx_n = 0;
      repeat (4) @(negedge clk);
      chk_reset_vals("reset");
      check("wen", {28'd0, rom_bus.romcode_WEN_A}, 32'd0);
      check("din", rom_bus.romcode_Din_A, 32'd0);
      check("clk_a", rom_bus.romcode_Clk_A, clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Plain read across a word boundary; prefetch at bytes 3 and 7.
      en0 = en_cnt;
      xact(8'h03, 32'h0, 8, 0);
      for (int i = 0; i < 8; i++) rx_expect(i, 8'(i + 1));
      check("rd8_bram_reads", 32'(en_cnt - en0), 32'd3);
      check("rd8_count", {16'd0, rd_count}, 32'd8);

      // Fast read from a mid-word address.
      xact(8'h0B, 32'h2, 4, 0);
      rx_expect(0, 8'h03); rx_expect(1, 8'h04); rx_expect(2, 8'h05); rx_expect(3, 8'h06);

      // Dual read.
      xact(8'h3B, 32'h0, 2, 0);
      rx_expect(0, 8'h01); rx_expect(1, 8'h02);

      // Unsupported opcode.
      en0 = en_cnt;
      xact(8'h9F, 32'h0, 0, 0);
      check("ignore_bram_reads", 32'(en_cnt - en0), 32'd0);
      check("ignore_cmd_err", cmd_err, 1'b1);
      xact(8'h03, 32'h10, 2, 0);
      rx_expect(0, 8'h11); rx_expect(1, 8'h12);

      // 24-bit address wrap.
      xact(8'h03, 32'hFF_FFFE, 4, 0);
      rx_expect(0, rom_byte(32'hFF_FFFE)); rx_expect(1, rom_byte(32'hFF_FFFF));
      rx_expect(2, 8'h01); rx_expect(3, 8'h02);

      // Abort after 3 data bits: no byte counted.
      rc0 = 32'(rd_count);
      xact(8'h03, 32'h20, 0, 3);
      check("abort_rd_count", {16'd0, rd_count}, 32'(rc0));

      // Reset in the middle of the address phase, csb held low across it.
      hp = 5; e_busy = 1'b1;
      @(negedge clk) csb = 1'b0;
      repeat (4) @(negedge clk);
      c = 8'h03;
      for (int i = 0; i < 8; i++)  spi_cycle(c[7-i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) spi_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      @(negedge clk) rst = 1'b0;
      m_rd = 0; m_err = 1'b0;
      e_busy = 1'b0;
      for (int i = 0; i < 30; i++) spi_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) csb = 1'b1;
      repeat (6) @(negedge clk);
      check("postrst_busy", busy, 1'b0);
      check("postrst_rd_count", {16'd0, rd_count}, 32'd0);
      xact(8'h03, 32'h0, 8, 0);
      for (int i = 0; i < 8; i++) rx_expect(i, 8'(i + 1));

      // Random traffic.
      for (int t = 0; t < 8; t++) begin
         r = $urandom_range(0, 4);
         case (r)
            0:       c = 8'h03;
            1:       c = 8'h0B;
            2:       c = 8'h3B;
            3:       c = 8'h03;
            default: c = 8'h05;
         endcase
         nb = $urandom_range(1, 9);
         if ($urandom_range(0, 4) == 0) xact(c, 32'($urandom_range(0, 32'hFF_FFFF)), 0, $urandom_range(1, 7));
         else                           xact(c, 32'($urandom_range(0, 32'hFF_FFFF)), nb, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/spiflash_rom_bridge.md
SPIFLASH_ROM_BRIDGE -- requirements
Module: spiflash_rom_bridge

Interface
REQ-001 SHALL provide parameter ADDR_BYTES, default 3, number of address bytes after the command byte (legal 3 or 4).
REQ-002 SHALL provide parameter DUMMY_CYCLES, default 8, spiclk cycles between the address and data phases for 0x0B/0x3B.
REQ-003 SHALL provide parameter DUAL_EN, default 1; 1 enables command 0x3B (dual-output fast read).
REQ-004 SHALL provide parameter ROM_AW, default 32, width of romcode_Addr_A.
REQ-005 ap_clk  in  1  single clock for all logic; spiclk is oversampled in this domain.
REQ-006 ap_rst  in  1  synchronous reset, active-high.
REQ-007 csb  in  1  SPI chip select, active-low.
REQ-008 spiclk  in  1  SPI clock, mode 0.
REQ-009 io0  in  1  MOSI in single mode.
REQ-010 io0_o / io0_oe  out  1 / 1  io0 drive value and enable, used only in the dual data phase.
REQ-011 io1  out  1  MISO; bit 1 of each pair in dual mode.
REQ-012 romcode_Addr_A  out  ROM_AW  BRAM byte address, word-aligned (bits [1:0]=0).
REQ-013 romcode_EN_A  out  1  BRAM read enable; romcode_WEN_A out 4, always 0; romcode_Din_A out 32, always 0.
REQ-014 romcode_Dout_A  in  32  BRAM read data, valid one ap_clk after EN_A.
REQ-015 romcode_Clk_A / romcode_Rst_A  out  1 / 1  equal to ap_clk / ap_rst.
REQ-016 busy  out  1  high while csb low and state != IDLE; cmd_err out 1 sticky flag, set on unsupported command.
REQ-017 rd_count  out  16  bytes delivered since reset, saturating at 0xFFFF.

Function
REQ-018 SHALL synchronise csb and spiclk through 2 flops and detect spiclk rise/fall from the synchronised copies; legal spiclk period >= 8 ap_clk.
REQ-019 SHALL sample io0 on synchronised spiclk rise and update io1/io0_o on fall, MSB first.
REQ-020 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-021 IDLE->CMD on synchronised csb falling; CMD collects 8 bits.
REQ-022 Command 0x03 -> ADDR -> DATA; 0x0B -> ADDR -> DUMMY -> DATA; 0x3B with DUAL_EN=1 -> ADDR -> DUMMY -> DATA(dual); any other value (incl. 0x3B with DUAL_EN=0) -> IGNORE, cmd_err set.
REQ-023 ADDR collects 8*ADDR_BYTES bits; DUMMY counts DUMMY_CYCLES spiclk rises (DUMMY_CYCLES=0 skips DUMMY).
REQ-024 On entering DATA, SHALL issue a BRAM read of address {A[ROM_AW-1:2],2'b00}; first data bit SHALL be driven on the first spiclk fall after the final address/dummy rise.
REQ-025 Byte select A[1:0], little-endian: lane 0 = Dout_A[7:0].
REQ-026 SHALL prefetch word+4 when the last byte of the current word starts shifting, so continuous reads never stall.
REQ-027 Single mode: 8 bits/byte on io1, io0_oe=0. Dual mode: 4 falls/byte, io1=even-numbered bit pairs' MSB (b7,b5,b3,b1), io0_o=(b6,b4,b2,b0), io0_oe=1.
REQ-028 Address SHALL increment per byte and wrap modulo 2^(8*ADDR_BYTES) and modulo 2^ROM_AW, whichever is smaller.
REQ-029 rd_count SHALL increment once per completed byte (last bit driven and following rise seen).
REQ-030 Synchronised csb high in any state SHALL force IDLE on the next ap_clk, io0_oe=0, discard partial byte; csb rise and spiclk edge in the same cycle: csb wins.
REQ-031 io1 SHALL be 0 outside DATA.

Reset
REQ-032 On ap_rst: state IDLE, io1=0, io0_o=0, io0_oe=0, romcode_EN_A=0, romcode_Addr_A=0, busy=0, cmd_err=0, rd_count=0, synchronisers to csb=1, spiclk=0.
REQ-033 ap_rst mid-transaction SHALL abort; after release the block waits for csb high then low before accepting a command.

Structure
REQ-034 Shared package spiflash_pkg SHALL hold state enum and command constants CMD_READ=0x03, CMD_FAST=0x0B, CMD_DUAL=0x3B.
REQ-035 One sub-module spiflash_edge_sync (2-flop sync + rise/fall detect), instantiated for spiclk and csb.

Verification
REQ-036 ROM word0=0x04030201, 0x03 addr 0x000000, read 8 bytes -> io1 bytes 01 02 03 04 then word1 bytes, rd_count=8.
REQ-037 0x0B addr 0x000002, 8 dummy, read 4 bytes -> 03 04 then word1[7:0],[15:8]; no stall at word boundary.
REQ-038 0x3B addr 0x000000, DUAL_EN=1 -> byte 0x01 appears as pairs (io1,io0_o)=(0,0),(0,0),(0,0),(0,1), io0_oe=1 only in DATA.
REQ-039 Command 0x9F -> IGNORE, cmd_err=1, io1 stays 0, no BRAM read; next csb cycle with 0x03 works.
REQ-040 csb raised after 3 data bits -> IDLE within 3 ap_clk, rd_count unchanged; ap_rst mid-ADDR -> all outputs at reset values.
REQ-041 ADDR_BYTES=3, ROM_AW=32, read from 0xFFFFFE for 4 bytes -> bytes at 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
